// File: rtl/ham_secded_stream.sv
// Streaming extended-Hamming SECDED decoder for 2^R-bit codewords.
// Two-stage valid/ready pipeline with per-word error flags and saturating error counters.
module ham_secded_stream #(
  parameter  int R     = 4,
  parameter  int CNT_W = 16,
  localparam int W     = 1 << R,
  localparam int K     = W - 1 - R
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_code,
  input  logic             correct_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_code,
  output logic [K-1:0]     out_data,
  output logic             out_single,
  output logic             out_double,
  output logic [R-1:0]     out_pos,
  input  logic             clear_counts,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count
);

  // Codeword position carrying data bit k: the k-th non-power-of-2 position above 2.
  function automatic int data_pos(input int k);
    int n;
    n        = 0;
    data_pos = 0;
    for (int p = 3; p < W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == k) data_pos = p;
        n++;
      end
    end
  endfunction

  logic             r_s1_valid;
  logic [W-1:0]     r_s1_code;
  logic             r_s1_cen;
  logic [R-1:0]     r_s1_syn;
  logic             r_s1_par;

  logic             r_s2_valid;
  logic [W-1:0]     r_out_code;
  logic [K-1:0]     r_out_data;
  logic             r_out_single;
  logic             r_out_double;
  logic [R-1:0]     r_out_pos;

  logic [CNT_W-1:0] r_corr_count;
  logic [CNT_W-1:0] r_uncorr_count;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_out_hs;
  logic [R-1:0]     w_syn;
  logic             w_single;
  logic             w_double;
  logic [W-1:0]     w_fixed;
  logic [K-1:0]     w_data;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;
  assign w_out_hs = r_s2_valid && out_ready;

  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    w_syn = '0;
    for (int i = 1; i < W; i++) begin
      if (in_code[i]) w_syn = w_syn ^ R'(i);
    end
  end

  assign w_single = r_s1_par;
  assign w_double = !r_s1_par && (r_s1_syn != '0);
  // A single error at syndrome 0 lands on the overall parity bit 0.
  assign w_fixed  = r_s1_code ^ (W'(r_s1_par && r_s1_cen) << r_s1_syn);

  for (genvar k = 0; k < K; k++) begin : g_data
    assign w_data[k] = w_fixed[data_pos(k)];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_cen   <= 1'b0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_code <= in_code;
        r_s1_cen  <= correct_en;
        r_s1_syn  <= w_syn;
        r_s1_par  <= ^in_code;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s2_valid   <= 1'b0;
      r_out_code   <= '0;
      r_out_data   <= '0;
      r_out_single <= 1'b0;
      r_out_double <= 1'b0;
      r_out_pos    <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_code   <= w_fixed;
        r_out_data   <= w_data;
        r_out_single <= w_single;
        r_out_double <= w_double;
        r_out_pos    <= r_s1_syn;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_corr_count   <= '0;
      r_uncorr_count <= '0;
    end else if (clear_counts) begin
      r_corr_count   <= '0;
      r_uncorr_count <= '0;
    end else if (w_out_hs) begin
      if (r_out_single && (r_corr_count != '1))   r_corr_count   <= r_corr_count + CNT_W'(1);
      if (r_out_double && (r_uncorr_count != '1)) r_uncorr_count <= r_uncorr_count + CNT_W'(1);
    end
  end

  assign out_valid    = r_s2_valid;
  assign out_code     = r_out_code;
  assign out_data     = r_out_data;
  assign out_single   = r_out_single;
  assign out_double   = r_out_double;
  assign out_pos      = r_out_pos;
  assign corr_count   = r_corr_count;
  assign uncorr_count = r_uncorr_count;

endmodule

// File: doc/ham_secded_stream.md
Name: ham_secded_stream

Overview:
- Parametrised successor to the 15-bit single-error-correcting hamFix corrector: extended Hamming SECDED decoder (Hamming plus overall parity) for any 2^R-bit codeword.
- Streaming valid/ready interface, 2-stage pipeline, per-word error flags and saturating error counters.
- Sits between a memory or link receiver and the consumer of corrected data.

Parameters:
- R, 4, Hamming parity bits; codeword width W = 2^R (default 16); data width K = 2^R-1-R (default 11)
- CNT_W, 16, width of each error counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- in_code  in  W  codeword; bit 0 = overall parity, bits 1..W-1 = Hamming positions 1..2^R-1
- correct_en  in  1  sampled with in_code; 1 = apply correction, 0 = report only
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the output word
- out_code  out  W  corrected (or passed-through) codeword
- out_data  out  K  data bits: non-power-of-2 positions ascending, LSB = position 3
- out_single  out  1  single-bit error detected
- out_double  out  1  uncorrectable double-bit error detected
- out_pos  out  R  syndrome / error position; 0 = bit 0 or no error
- clear_counts  in  1  synchronous clear pulse for both counters
- corr_count  out  CNT_W  number of single errors delivered; saturates at all-ones
- uncorr_count  out  CNT_W  number of double errors delivered; saturates at all-ones

Behaviour:
- Reset (async, active-high): all pipeline valids 0, out_* data 0, counters 0, in_ready 1 after reset deasserts.
- Stage 1 (S1) captures in_code and correct_en on input handshake (in_valid & in_ready), together with:
  - s = XOR of indices i (1..W-1) where bit i = 1
  - p = XOR of all W bits
- Stage 2 (S2) classifies and registers the outputs; latency in→out is 2 cycles with no stall.
- Classification:
  - s=0, p=0: clean.
  - p=1: single error at position s (s=0 means bit 0). If correct_en, flip that bit.
  - s≠0, p=0: double error; code never modified.
- out_data is extracted from the corrected codeword. out_pos = s in all cases.
- Handshake:
  - S2 advances when !S2.valid | out_ready.
  - S1 advances when !S1.valid | S2 advances.
  - in_ready = S1 advances (combinational from out_ready, no combinational in→out path).
  - Full throughput: 1 word/cycle while out_ready = 1.
  - out_* stable while out_valid & !out_ready.
- Counters:
  - Increment on output handshake when out_single (corr) or out_double (uncorr), with correct_en ignored.
  - Saturate at 2^CNT_W-1.
  - clear_counts wins over a same-cycle increment.
- Reset mid-stream drops in-flight words; no output handshake occurs for them.

Test Plan (R=4):
- Clean: in_code=16'h000F (data 11'h001) → 2 cycles later out_valid, out_code=16'h000F, out_data=11'h001, single=double=0, out_pos=0.
- Single error: in 16'h002F (bit 5 flipped), correct_en=1 → out_code=16'h000F, out_single=1, out_pos=5, corr_count=1. With correct_en=0 → out_code=16'h002F, out_single=1.
- Parity-bit error: in 16'h000E → out_code=16'h000F, out_single=1, out_pos=0.
- Double error: in 16'h006F (bits 5,6) → out_code=16'h006F, out_double=1, out_pos=3, uncorr_count=1.
- Backpressure: stream all 2048 encoded words with one flipped bit each, out_ready random 50% → every word delivered in order, corrected, no loss or duplication, in_ready=0 only when both stages are full and out_ready=0.
- Counters: CNT_W=2, 5 single errors → corr_count sticks at 3; clear_counts on the same cycle as a 6th single error → 0. Reset asserted with 2 words in flight → out_valid=0 immediately, counters 0.
